// File: rtl/btb_update_queue_pkg.sv
// Shared types and default sizes for the BTB update queue.
//   UPDQ_ENTRY : one queued BTB update {valid, branch_PC, target_PC}
//   UPDQ_IDX   : queue slot index for the default depth
package btb_update_queue_pkg;

    localparam int unsigned UPDQ_ADDR_W     = 32;
    localparam int unsigned UPDQ_DEPTH      = 8;
    localparam int unsigned UPDQ_NUM_BR     = 2;
    localparam int unsigned UPDQ_DROP_CNT_W = 16;

    typedef logic [UPDQ_ADDR_W-1:0] ADDR;

    typedef logic [$clog2(UPDQ_DEPTH)-1:0] UPDQ_IDX;

    typedef struct packed {
        logic valid;
        ADDR  branch_PC;
        ADDR  target_PC;
    } UPDQ_ENTRY;

endpackage

// File: rtl/updq_lane_merge.sv
// Combinational lane resolver for the BTB update queue.
// Collapses same-PC taken lanes (highest lane wins) and looks the
// survivors up against the queued PCs.
//   br_valid_i/br_taken_i/br_pc_i : resolution lanes
//   q_pc_i/q_match_en_i           : queued PCs and which slots may coalesce
//   allocate_o                    : lane needs a new slot
//   coalesce_hit_o/coalesce_idx_o : lane overwrites the target of a queued slot
module updq_lane_merge
    import btb_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = UPDQ_DEPTH,
    parameter int unsigned NUM_BR = UPDQ_NUM_BR
) (
    input  logic [NUM_BR-1:0]                      br_valid_i,
    input  logic [NUM_BR-1:0]                      br_taken_i,
    input  ADDR  [NUM_BR-1:0]                      br_pc_i,
    input  ADDR  [DEPTH-1:0]                       q_pc_i,
    input  logic [DEPTH-1:0]                       q_match_en_i,
    output logic [NUM_BR-1:0]                      allocate_o,
    output logic [NUM_BR-1:0]                      coalesce_hit_o,
    output logic [NUM_BR-1:0][$clog2(DEPTH)-1:0]   coalesce_idx_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [NUM_BR-1:0] cand;
    logic [NUM_BR-1:0] survivor;

    assign cand = br_valid_i & br_taken_i;

    // A lane is superseded when a higher lane carries the same PC.
    always_comb begin
        survivor = cand;
        for (int i = 0; i < int'(NUM_BR); i++) begin
            for (int j = i + 1; j < int'(NUM_BR); j++) begin
                if (cand[j] && (br_pc_i[j] == br_pc_i[i])) begin
                    survivor[i] = 1'b0;
                end
            end
        end
    end

    // Survivors matching an eligible queued slot coalesce; the rest allocate.
    always_comb begin
        coalesce_hit_o = '0;
        coalesce_idx_o = '0;
        for (int i = 0; i < int'(NUM_BR); i++) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                if (survivor[i] && q_match_en_i[e] && (q_pc_i[e] == br_pc_i[i])) begin
                    coalesce_hit_o[i] = 1'b1;
                    coalesce_idx_o[i] = IDX_W'(e);
                end
            end
        end
        allocate_o = survivor & ~coalesce_hit_o;
    end

endmodule

// File: rtl/btb_update_queue.sv
// BTB update queue: buffers resolved taken branches, coalesces repeat PCs,
// drains one update per cycle into the BTB and counts dropped updates.
//   clock, reset                      : clock, synchronous active-high reset
//   br_valid/br_taken/br_PC/br_target_PC : resolution lanes
//   resolving_*                       : registered head entry to the BTB
//   queue_count                       : registered occupancy
//   drop_count                        : saturating count of discarded updates
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = UPDQ_DEPTH,
    parameter int unsigned NUM_BR     = UPDQ_NUM_BR,
    parameter int unsigned DROP_CNT_W = UPDQ_DROP_CNT_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_BR-1:0]         br_valid,
    input  logic [NUM_BR-1:0]         br_taken,
    input  ADDR  [NUM_BR-1:0]         br_PC,
    input  ADDR  [NUM_BR-1:0]         br_target_PC,
    output logic                      resolving_valid,
    output ADDR                       resolving_branch_PC,
    output ADDR                       resolving_target_PC,
    output logic [$clog2(DEPTH):0]    queue_count,
    output logic [DROP_CNT_W-1:0]     drop_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    UPDQ_ENTRY              entries_q [DEPTH];
    UPDQ_ENTRY              entries_d [DEPTH];
    logic [IDX_W-1:0]       head_q, head_d;
    logic [IDX_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DROP_CNT_W-1:0]  drop_q, drop_d;
    UPDQ_ENTRY              out_q, out_d;

    ADDR  [DEPTH-1:0]               q_pc;
    logic [DEPTH-1:0]               q_match_en;
    logic [NUM_BR-1:0]              lane_alloc;
    logic [NUM_BR-1:0]              lane_hit;
    logic [NUM_BR-1:0][IDX_W-1:0]   lane_hit_idx;

    logic                   deq;
    logic [CNT_W-1:0]       free_slots;
    logic [CNT_W-1:0]       alloc_n;
    logic [CNT_W-1:0]       drop_n;
    logic [DROP_CNT_W:0]    drop_sum;

    // The head is always dequeued when valid, so it never takes a coalesce.
    always_comb begin
        for (int e = 0; e < int'(DEPTH); e++) begin
            q_pc[e]       = entries_q[e].branch_PC;
            q_match_en[e] = entries_q[e].valid && (IDX_W'(e) != head_q);
        end
    end

    updq_lane_merge #(
        .DEPTH  (DEPTH),
        .NUM_BR (NUM_BR)
    ) u_lane_merge (
        .br_valid_i     (br_valid),
        .br_taken_i     (br_taken),
        .br_pc_i        (br_PC),
        .q_pc_i         (q_pc),
        .q_match_en_i   (q_match_en),
        .allocate_o     (lane_alloc),
        .coalesce_hit_o (lane_hit),
        .coalesce_idx_o (lane_hit_idx)
    );

    // Next-state: dequeue head, apply coalesces, append within start-of-cycle free space.
    always_comb begin
        entries_d  = entries_q;
        deq        = (count_q != '0);
        free_slots = CNT_W'(DEPTH) - count_q;
        alloc_n    = '0;
        drop_n     = '0;

        if (deq) begin
            entries_d[head_q].valid = 1'b0;
        end

        for (int i = 0; i < int'(NUM_BR); i++) begin
            if (lane_hit[i]) begin
                entries_d[lane_hit_idx[i]].target_PC = br_target_PC[i];
            end else if (lane_alloc[i]) begin
                if (alloc_n < free_slots) begin
                    entries_d[tail_q + IDX_W'(alloc_n)].valid     = 1'b1;
                    entries_d[tail_q + IDX_W'(alloc_n)].branch_PC = br_PC[i];
                    entries_d[tail_q + IDX_W'(alloc_n)].target_PC = br_target_PC[i];
                    alloc_n = alloc_n + CNT_W'(1);
                end else begin
                    drop_n = drop_n + CNT_W'(1);
                end
            end
        end

        head_d  = head_q + IDX_W'(deq);
        tail_d  = tail_q + IDX_W'(alloc_n);
        count_d = count_q + alloc_n - CNT_W'(deq);

        drop_sum = {1'b0, drop_q} + (DROP_CNT_W + 1)'(drop_n);
        drop_d   = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];

        // Present the next head straight from the register inputs.
        out_d = entries_d[head_d];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                entries_q[e] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            out_q   <= '0;
        end else begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                entries_q[e] <= entries_d[e];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            out_q   <= out_d;
        end
    end

    assign resolving_valid     = out_q.valid;
    assign resolving_branch_PC = out_q.branch_PC;
    assign resolving_target_PC = out_q.target_PC;
    assign queue_count         = count_q;
    assign drop_count          = drop_q;

endmodule
